// File: rtl/life_window.sv
// life_window
//   Converts a raster-order serial stream of cell states (one bit per cell,
//   X*Y cells per frame) into the 3x3 neighbourhood of every cell, one window
//   per output handshake. Cells outside the grid read as dead (no wrap).
//   History is a 2X+3 bit shift register; frame and row edges are handled by
//   masking taps according to the centre position.
//
// Ports
//   clk        : clock, all state on rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : in_data holds the next raster cell
//   in_ready   : cell accepted on in_valid & in_ready
//   in_data    : cell state, 1 = alive
//   out_valid  : window outputs hold a valid neighbourhood
//   out_ready  : window consumed on out_valid & out_ready
//   c,l,r,u,d  : centre, left, right, up (row y-1), down (row y+1)
//   lu,ld,ru,rd: diagonal neighbours
//   out_x      : column of the centre cell
//   out_y      : row of the centre cell
//   out_last   : window is for cell (X-1,Y-1)
module life_window #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             c,
  output logic             l,
  output logic             r,
  output logic             u,
  output logic             d,
  output logic             lu,
  output logic             ld,
  output logic             ru,
  output logic             rd,
  output logic [LOG2X-1:0] out_x,
  output logic [LOG2Y-1:0] out_y,
  output logic             out_last
);

  localparam int SRW = 2 * X + 3;
  localparam int CW  = LOG2X + LOG2Y;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  logic [SRW-1:0]   sr;
  logic [SRW-1:0]   sr_next;
  logic [CW-1:0]    in_cnt;
  logic [LOG2X-1:0] wx;
  logic [LOG2Y-1:0] wy;

  logic adv;
  logic accept;
  logic shift_en;
  logic load_en;
  logic shift_bit;
  logic at_left;
  logic at_right;
  logic at_top;
  logic at_bottom;
  logic [8:0] win;

  // Handshake and shift control. In FLUSH the remaining windows are pushed
  // out by shifting in dead cells whenever the output slot can take one.
  always_comb begin
    adv       = ~out_valid | out_ready;
    in_ready  = 1'b0;
    case (state)
      FILL:    in_ready = 1'b1;
      RUN:     in_ready = adv;
      default: in_ready = 1'b0;
    endcase
    accept    = in_valid & in_ready;
    shift_en  = (state == FLUSH) ? adv : accept;
    load_en   = ((state == RUN) & accept) | ((state == FLUSH) & adv);
    shift_bit = (state == FLUSH) ? 1'b0 : in_data;
    sr_next   = {sr[SRW-2:0], shift_bit};
  end

  // Neighbourhood taps from the post-shift register, masked at grid edges.
  // wx/wy track the position of the next window to be loaded.
  always_comb begin
    at_left   = (wx == '0);
    at_right  = (wx == LOG2X'(X - 1));
    at_top    = (wy == '0);
    at_bottom = (wy == LOG2Y'(Y - 1));
    // order: c, l, r, u, d, lu, ld, ru, rd
    win[8] = sr_next[X+1];
    win[7] = sr_next[X+2]   & ~at_left;
    win[6] = sr_next[X]     & ~at_right;
    win[5] = sr_next[2*X+1] & ~at_top;
    win[4] = sr_next[1]     & ~at_bottom;
    win[3] = sr_next[2*X+2] & ~at_left  & ~at_top;
    win[2] = sr_next[2]     & ~at_left  & ~at_bottom;
    win[1] = sr_next[2*X]   & ~at_right & ~at_top;
    win[0] = sr_next[0]     & ~at_right & ~at_bottom;
  end

  // Main state: shift register, window registers, position counters and FSM.
  // in_cnt counts accepted cells in FILL/RUN and loaded windows in FLUSH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      sr        <= '0;
      in_cnt    <= '0;
      wx        <= '0;
      wy        <= '0;
      out_valid <= 1'b0;
      {c, l, r, u, d, lu, ld, ru, rd} <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else begin
      if (shift_en) begin
        sr <= sr_next;
      end

      if (load_en) begin
        {c, l, r, u, d, lu, ld, ru, rd} <= win;
        out_x     <= wx;
        out_y     <= wy;
        out_last  <= at_right & at_bottom;
        out_valid <= 1'b1;
        if (at_right) begin
          wx <= '0;
          wy <= at_bottom ? '0 : wy + 1'b1;
        end else begin
          wx <= wx + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        FILL: begin
          if (accept) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == CW'(X)) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (in_cnt == CW'(X * Y - 1)) begin
              state  <= FLUSH;
              in_cnt <= '0;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (adv) begin
            if (in_cnt == CW'(X)) begin
              state  <= FILL;
              in_cnt <= '0;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= FILL;
          in_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_window.sv
// tb_life_window
//   Directed bench for life_window (X=8, Y=8). A reference model derives each
//   expected neighbourhood straight from the frame contents by grid lookup,
//   and a compare process checks every valid output cycle against it.
module tb_life_window;

  localparam int X = 8;
  localparam int Y = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_data = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic       c, l, r, u, d, lu, ld, ru, rd;
  logic [2:0] out_x;
  logic [2:0] out_y;
  logic       out_last;

  int n_checks = 0;
  int n_fails = 0;

  logic [63:0] frame_mem [0:7];
  int frame_base = 0;
  int local_cnt = 0;
  int last_total = 0;

  life_window #(.X(X), .Y(Y), .LOG2X(3), .LOG2Y(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .l(l), .r(r), .u(u), .d(d),
    .lu(lu), .ld(ld), .ru(ru), .rd(rd),
    .out_x(out_x), .out_y(out_y), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Reference model: dead outside the grid, otherwise the frame bit.
  function automatic logic cell_at(input logic [63:0] f, input int x, input int y);
    if (x < 0 || x >= X || y < 0 || y >= Y) return 1'b0;
    return f[y*X + x];
  endfunction

  // Expected window ordered {c,l,r,u,d,lu,ld,ru,rd}.
  function automatic logic [8:0] exp_win(input logic [63:0] f, input int x, input int y);
    return {cell_at(f, x, y),     cell_at(f, x-1, y),   cell_at(f, x+1, y),
            cell_at(f, x, y-1),   cell_at(f, x, y+1),   cell_at(f, x-1, y-1),
            cell_at(f, x-1, y+1), cell_at(f, x+1, y-1), cell_at(f, x+1, y+1)};
  endfunction

  function automatic logic [15:0] bundle();
    return {c, l, r, u, d, lu, ld, ru, rd, out_x, out_y, out_last};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] req);
    n_checks++;
    if (got !== req) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Compare process: every valid output cycle is checked against the model;
  // a handshake advances to the next expected window.
  always @(negedge clk) begin
    int fr;
    int idx;
    logic [15:0] req;
    if (!rst_n) begin
      local_cnt = 0;
    end else if (out_valid) begin
      fr  = frame_base + local_cnt / 64;
      idx = local_cnt % 64;
      if (fr > 7) begin
        checkOutput("window_overrun", 16'(fr), 16'd7);
      end else begin
        req = {exp_win(frame_mem[fr], idx % 8, idx / 8),
               3'(idx % 8), 3'(idx / 8), (idx == 63)};
        checkOutput("window", bundle(), req);
      end
      if (out_ready) begin
        local_cnt = local_cnt + 1;
        if (out_last) last_total = last_total + 1;
      end
    end
  end

  // Present one cell and hold it until accepted (bounded wait).
  task automatic applyStimulus(input logic b);
    int n;
    logic took;
    n = 0;
    took = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!took && n < 50) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!took) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL accept_timeout: got no accept, required accept within 50 cycles");
    end
  endtask

  // Hold out_ready low for 5 cycles and require frozen outputs.
  task automatic stallCheck(input string name);
    logic [15:0] snap;
    out_ready = 1'b0;
    snap = bundle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput({name, "_frozen"}, bundle(), snap);
      checkOutput({name, "_ready_valid"}, {14'd0, in_ready, out_valid}, 16'b01);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    n_fails++;
    summary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] ones;
    logic [63:0] blinker;
    ones = '1;
    blinker = '0;
    blinker[19] = 1'b1;
    blinker[27] = 1'b1;
    blinker[35] = 1'b1;

    frame_mem[0] = 64'hA5C3_0F96_3C5A_E178;
    frame_mem[1] = ones;
    frame_mem[2] = '0;
    frame_mem[3] = blinker;
    frame_mem[4] = 64'h1234_5678_9ABC_DEF0;
    frame_mem[5] = 64'h0F0F_3366_C3A5_9E71;
    frame_mem[6] = '0;
    frame_mem[7] = '0;

    // hand-computed expectations that pin the model
    checkOutput("model_ones_0_0", 16'(exp_win(ones, 0, 0)), 16'b101010001);
    checkOutput("model_ones_3_3", 16'(exp_win(ones, 3, 3)), 16'b111111111);
    checkOutput("model_ones_7_7", 16'(exp_win(ones, 7, 7)), 16'b110101000);
    checkOutput("model_ones_7_0", 16'(exp_win(ones, 7, 0)), 16'b110010100);
    checkOutput("model_blink_3_3", 16'(exp_win(blinker, 3, 3)), 16'b100110000);
    checkOutput("model_blink_2_3", 16'(exp_win(blinker, 2, 3)), 16'b001000011);
    checkOutput("model_blink_4_2", 16'(exp_win(blinker, 4, 2)), 16'b010000100);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_window", bundle(), 16'd0);
    checkOutput("reset_ready_valid", {14'd0, in_ready, out_valid}, 16'b10);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // frame 0: latency and frame-end flush length
    for (int i = 0; i < 64; i++) begin
      applyStimulus(frame_mem[0][i]);
      if (i == 8) checkOutput("latency_not_yet", {15'd0, out_valid}, 16'd0);
      if (i == 9) checkOutput("latency_first", {9'd0, out_valid, out_x, out_y}, 16'b1_000_000);
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checkOutput("flush_in_ready_low", {15'd0, in_ready}, 16'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("flush_done_in_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;

    // frame 1: all ones, with stalls in RUN and in FLUSH
    for (int i = 0; i < 64; i++) begin
      if (i == 20) begin
        in_valid = 1'b1;
        in_data  = 1'b1;
        stallCheck("stall_run");
      end
      applyStimulus(frame_mem[1][i]);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    stallCheck("stall_flush");

    // frames 2 and 3 back to back with no gap
    for (int i = 0; i < 64; i++) applyStimulus(frame_mem[2][i]);
    for (int i = 0; i < 64; i++) applyStimulus(frame_mem[3][i]);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    checkOutput("windows_after_4_frames", 16'(local_cnt), 16'd256);
    checkOutput("last_after_4_frames", 16'(last_total), 16'd4);

    // frame 4 interrupted by reset at cell 30
    for (int i = 0; i < 30; i++) applyStimulus(frame_mem[4][i]);
    rst_n = 1'b0;
    frame_base = 5;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midreset_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("midreset_in_ready", {15'd0, in_ready}, 16'd1);

    // frame 5 after reset starts at (0,0)
    for (int i = 0; i < 64; i++) applyStimulus(frame_mem[5][i]);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    checkOutput("windows_after_reset", 16'(local_cnt), 16'd64);
    checkOutput("last_total_final", 16'(last_total), 16'd5);

    summary();
    $finish;
  end

endmodule
